// File: rtl/binary_to_ascii_decimal.sv
// Serial binary-to-decimal converter producing a fixed-width ASCII string.
// A captured value is shifted MSB-first through a double-dabble BCD
// accumulator, one bit per clock, then formatted with leading-zero blanking
// (or a row of '-' when the value does not fit in NUM_DIGITS characters).
module binary_to_ascii_decimal #(
  parameter int NUM_DIGITS           = 10,
  parameter int BITS_IN              = 40,
  parameter int BITS_PER_ASCII_DIGIT = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [BITS_IN-1:0]                         binary_in,
  input  logic                                       start,
  output logic [NUM_DIGITS*BITS_PER_ASCII_DIGIT-1:0] ascii_out,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       overflow
);

  // Decimal digits needed to hold any BITS_IN-bit value (floor(B*log10 2)+1),
  // never fewer than the digits shown on the output.
  localparam int BCD_RAW    = (BITS_IN * 30103) / 100000 + 1;
  localparam int BCD_DIGITS = (BCD_RAW > NUM_DIGITS) ? BCD_RAW : NUM_DIGITS;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CMP_W      = BITS_IN + 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(BITS_IN + 1);
  localparam int CH_W       = BITS_PER_ASCII_DIGIT;
  localparam int OUT_W      = NUM_DIGITS * CH_W;

  localparam logic [CH_W-1:0]  CH_SPACE = CH_W'(8'h20);
  localparam logic [CH_W-1:0]  CH_DASH  = CH_W'(8'h2D);
  localparam logic [OUT_W-1:0] BLANK    = {NUM_DIGITS{CH_SPACE}};

  // Largest value that still fits: 10^NUM_DIGITS - 1, in a width that
  // can hold it regardless of BITS_IN.
  function automatic logic [CMP_W-1:0] max_value();
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < NUM_DIGITS; i++) p = p * CMP_W'(10);
    return p - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_VALUE = max_value();

  // One double-dabble step: correct every nibble >= 5, then shift in a bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // Render the low NUM_DIGITS BCD digits as ASCII with leading blanks; the
  // units character is always printed so zero shows as a single '0'.
  function automatic logic [OUT_W-1:0] format_ascii(input logic [BCD_W-1:0] bcd,
                                                    input logic             ovf);
    logic [OUT_W-1:0] s;
    logic             seen;
    logic [3:0]       d;
    s    = BLANK;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (ovf) begin
        s[i*CH_W +: CH_W] = CH_DASH;
      end else if (d == 4'd0 && !seen && i != 0) begin
        s[i*CH_W +: CH_W] = CH_SPACE;
      end else begin
        s[i*CH_W +: CH_W] = CH_W'({4'h3, d});
        seen              = 1'b1;
      end
    end
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t             state_q, state_d;
  logic [BITS_IN-1:0] value_q, value_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [OUT_W-1:0]   ascii_q, ascii_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  // Next-state and datapath update for the capture / shift / format sequence.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ascii_d    = ascii_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d    = binary_in;
          ovf_pend_d = (CMP_W'(binary_in) > MAX_VALUE);
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = dabble_step(bcd_q, value_q[BITS_IN-1]);
        value_d = value_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BITS_IN - 1)) state_d = FORMAT;
      end
      FORMAT: begin
        ascii_d    = format_ascii(bcd_q, ovf_pend_q);
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ascii_q    <= BLANK;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ascii_q    <= ascii_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Working datapath registers; always reinitialised when a start is accepted.
  always_ff @(posedge clk) begin
    value_q    <= value_d;
    bcd_q      <= bcd_d;
    cnt_q      <= cnt_d;
    ovf_pend_q <= ovf_pend_d;
  end

  assign ascii_out = ascii_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_binary_to_ascii_decimal.sv
// Directed bench for binary_to_ascii_decimal with the default parameters.
module tb_binary_to_ascii_decimal;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] binary_in;
  logic        start;
  logic [79:0] ascii_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [79:0] BLANK = 80'h20202020202020202020;

  binary_to_ascii_decimal #(
    .NUM_DIGITS(10), .BITS_IN(40), .BITS_PER_ASCII_DIGIT(8)
  ) dut (
    .clk(clk), .reset(reset), .binary_in(binary_in), .start(start),
    .ascii_out(ascii_out), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] val;
    logic [79:0] exp_ascii;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Count edges after the current one until done is seen (0 if never within bound).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_conv(input int idx);
    int n;
    binary_in = vecs[idx].val;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check($sformatf("busy_after_start[%0d]", idx), 80'(busy), 80'd1);
    wait_done(n);
    check($sformatf("latency[%0d]", idx), 80'(n), 80'd41);
    check($sformatf("ascii[%0d]", idx), ascii_out, vecs[idx].exp_ascii);
    check($sformatf("overflow[%0d]", idx), 80'(overflow), 80'(vecs[idx].exp_ovf));
    check($sformatf("busy_in_done[%0d]", idx), 80'(busy), 80'd0);
    tick();
    check($sformatf("done_one_cycle[%0d]", idx), 80'(done), 80'd0);
    check($sformatf("ascii_hold[%0d]", idx), ascii_out, vecs[idx].exp_ascii);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{40'd0,             80'h20202020202020202030, 1'b0};
    vecs[1] = '{40'd9001,          80'h20202020202039303031, 1'b0};
    vecs[2] = '{40'd10002,         80'h20202020203130303032, 1'b0};
    vecs[3] = '{40'd9999999999,    80'h39393939393939393939, 1'b0};
    vecs[4] = '{40'd10000000000,   80'h2D2D2D2D2D2D2D2D2D2D, 1'b1};
    vecs[5] = '{40'd7,             80'h20202020202020202037, 1'b0};
    vecs[6] = '{40'hFF_FFFF_FFFF,  80'h2D2D2D2D2D2D2D2D2D2D, 1'b1};
    vecs[7] = '{40'd1234567890,    80'h31323334353637383930, 1'b0};
    vecs[8] = '{40'd100,           80'h20202020202020313030, 1'b0};
    vecs[9] = '{40'd1000000000,    80'h31303030303030303030, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    binary_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 80'(busy), 80'd0);
    check("reset_done", 80'(done), 80'd0);
    check("reset_overflow", 80'(overflow), 80'd0);
    check("reset_ascii", ascii_out, BLANK);

    for (int i = 0; i < 10; i++) run_conv(i);

    // start held through a conversion; input changed mid-way must be ignored
    binary_in = 40'd9001;
    start     = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    binary_in = 40'd5;
    check("held_start_busy", 80'(busy), 80'd1);
    wait_done(n);
    check("held_first_latency", 80'(n), 80'd21);
    check("held_first_ascii", ascii_out, 80'h20202020202039303031);
    // start still high in the done cycle: next conversion accepted at this edge
    tick();
    start = 1'b0;
    check("b2b_busy", 80'(busy), 80'd1);
    wait_done(n);
    check("b2b_latency", 80'(n), 80'd41);
    check("b2b_ascii", ascii_out, 80'h20202020202020202035);

    // reset 20 cycles into a conversion aborts it
    binary_in = 40'd9001;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("abort_busy_before", 80'(busy), 80'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_ascii", ascii_out, BLANK);
    check("abort_overflow", 80'(overflow), 80'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", 80'(seen), 80'd0);

    // reset has priority over a simultaneous start
    start = 1'b1;
    reset = 1'b1;
    binary_in = 40'd42;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_prio_busy", 80'(busy), 80'd0);

    // converter still works after the abort
    run_conv(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
